// File: rtl/slc3_key_debounce.sv
// Run/Continue key conditioning for the SLC-3 top level: synchronise the raw
// active-low keys, debounce them, and emit a debounced level plus one press pulse.
module slc3_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic Continue,
  output logic run_pulse,
  output logic continue_pulse,
  output logic run_level,
  output logic continue_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [1:0] key_raw;
  logic [1:0] pulse_vec;
  logic [1:0] level_vec;

  assign key_raw = {Continue, Run};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   s;
      state_t                 state_reg, state_next;
      logic [CW-1:0]          cnt_reg, cnt_next;
      logic                   pulse_reg, pulse_next;
      logic                   level_reg, level_next;

      // Released keys read as 1, so the synchroniser comes out of reset "released".
      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          sync_reg <= '1;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], key_raw[gi]};
        end
      end

      assign s = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          pulse_reg <= 1'b0;
          level_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          pulse_reg <= pulse_next;
          level_reg <= level_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pulse_next = 1'b0;
        unique case (state_reg)
          IDLE: begin
            if (!s) begin
              state_next = PRESS_WAIT;
              cnt_next   = CNT_ONE;
            end else begin
              cnt_next = '0;
            end
          end
          PRESS_WAIT: begin
            if (s) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
              state_next = PRESSED;
              cnt_next   = '0;
              pulse_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          PRESSED: begin
            if (s) begin
              state_next = RELEASE_WAIT;
              cnt_next   = CNT_ONE;
            end
          end
          RELEASE_WAIT: begin
            // A low sample here is release bounce: back to PRESSED without a pulse.
            if (!s) begin
              state_next = PRESSED;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        endcase
        level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
      end

      assign pulse_vec[gi] = pulse_reg;
      assign level_vec[gi] = level_reg;
    end
  endgenerate

  assign run_pulse      = pulse_vec[0];
  assign continue_pulse = pulse_vec[1];
  assign run_level      = level_vec[0];
  assign continue_level = level_vec[1];

endmodule

// File: tb/tb_slc3_key_debounce.sv
// Bench for slc3_key_debounce: run-length reference model checked every cycle,
// directed scenarios with literal pulse/level edge numbers, then random key traffic.
module tb_slc3_key_debounce;

  localparam int D = 4;
  localparam int S = 2;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Run = 1'b1;
  logic Continue = 1'b1;
  logic run_pulse, continue_pulse, run_level, continue_level;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: raw key seen by the debouncer S edges after it is sampled;
  // the level flips once D+1 consecutive samples disagree with it.
  bit q_run[$];
  bit q_cont[$];
  int run_len[2];
  bit m_lvl[2];
  bit m_pls[2];

  int run_p[$];
  int cont_p[$];
  int run_fall[$];
  bit prev_run_level = 1'b0;

  slc3_key_debounce #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES(S)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Run(Run),
    .Continue(Continue),
    .run_pulse(run_pulse),
    .continue_pulse(continue_pulse),
    .run_level(run_level),
    .continue_level(continue_level)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at t=%0t edge %0d: got %0d, expected %0d", name, $time, edge_n, got, exp);
    end
  endtask

  task automatic model_step(input int ch, input bit x);
    m_pls[ch] = 1'b0;
    // x==lvl means the sample disagrees (pressed key reads 0, pressed level is 1).
    if (x == m_lvl[ch]) begin
      run_len[ch]++;
      if (run_len[ch] == D + 1) begin
        m_lvl[ch]   = !m_lvl[ch];
        m_pls[ch]   = m_lvl[ch];
        run_len[ch] = 0;
      end
    end else begin
      run_len[ch] = 0;
    end
  endtask

  always @(posedge Clk) begin
    if (!Reset) begin
      q_run = {};
      q_cont = {};
      repeat (S) begin
        q_run.push_back(1'b1);
        q_cont.push_back(1'b1);
      end
      for (int c = 0; c < 2; c++) begin
        run_len[c] = 0;
        m_lvl[c]   = 1'b0;
        m_pls[c]   = 1'b0;
      end
      edge_n = 0;
    end else begin
      bit xr, xc;
      edge_n++;
      xr = q_run.pop_front();
      xc = q_cont.pop_front();
      q_run.push_back(Run);
      q_cont.push_back(Continue);
      model_step(0, xr);
      model_step(1, xc);
    end
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      check("reset_run_pulse", int'(run_pulse), 0);
      check("reset_cont_pulse", int'(continue_pulse), 0);
      check("reset_run_level", int'(run_level), 0);
      check("reset_cont_level", int'(continue_level), 0);
    end else begin
      check("run_pulse", int'(run_pulse), int'(m_pls[0]));
      check("cont_pulse", int'(continue_pulse), int'(m_pls[1]));
      check("run_level", int'(run_level), int'(m_lvl[0]));
      check("cont_level", int'(continue_level), int'(m_lvl[1]));
      if (run_pulse) run_p.push_back(edge_n);
      if (continue_pulse) cont_p.push_back(edge_n);
      if (prev_run_level && !run_level) run_fall.push_back(edge_n);
    end
    prev_run_level = run_level;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic clear_logs();
    run_p = {};
    cont_p = {};
    run_fall = {};
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick(2);
    Reset = 1'b1;
    clear_logs();
  endtask

  task automatic check_edges(input string name, input int got[$], input int n,
                             input int e0, input int e1);
    check({name, "_count"}, got.size(), n);
    if (n > 0 && got.size() > 0) check({name, "_first"}, got[0], e0);
    if (n > 1 && got.size() > 1) check({name, "_second"}, got[1], e1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hr_run, hr_cont;
    tick(1);
    do_reset();

    // Clean press before edge 10.
    tick(9);
    Run = 1'b0;
    tick(20);
    Run = 1'b1;
    tick(15);
    check_edges("clean_run_pulse", run_p, 1, 16, 0);
    check_edges("clean_cont_pulse", cont_p, 0, 0, 0);
    $display("txn clean_press: run pulses=%0d", run_p.size());

    // Glitch of four low cycles.
    do_reset();
    tick(9);
    Run = 1'b0;
    tick(4);
    Run = 1'b1;
    tick(15);
    check_edges("glitch_run_pulse", run_p, 0, 0, 0);
    $display("txn glitch: run pulses=%0d", run_p.size());

    // Bounce 0/1 for six cycles, then stable low from before edge 16.
    do_reset();
    tick(9);
    for (int i = 0; i < 6; i++) begin
      Run = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    Run = 1'b0;
    tick(15);
    Run = 1'b1;
    tick(12);
    check_edges("bounce_run_pulse", run_p, 1, 22, 0);
    $display("txn bounce: run pulses=%0d", run_p.size());

    // Long hold, release, re-press.
    do_reset();
    tick(9);
    Run = 1'b0;
    tick(50);
    Run = 1'b1;
    tick(10);
    Run = 1'b0;
    tick(10);
    Run = 1'b1;
    tick(15);
    check_edges("hold_run_pulse", run_p, 2, 16, 76);
    check_edges("hold_run_fall", run_fall, 2, 66, 86);
    $display("txn long_hold: run pulses=%0d falls=%0d", run_p.size(), run_fall.size());

    // Simultaneous keys before edge 5.
    do_reset();
    tick(4);
    Run = 1'b0;
    Continue = 1'b0;
    tick(10);
    Run = 1'b1;
    Continue = 1'b1;
    tick(12);
    check_edges("simul_run_pulse", run_p, 1, 11, 0);
    check_edges("simul_cont_pulse", cont_p, 1, 11, 0);
    $display("txn simultaneous: run=%0d cont=%0d", run_p.size(), cont_p.size());

    // Reset mid-PRESS_WAIT, then mid-PRESSED, key held throughout.
    do_reset();
    tick(3);
    Run = 1'b0;
    tick(5);
    check_edges("pw_no_pulse_yet", run_p, 0, 0, 0);
    Reset = 1'b0;
    tick(2);
    Reset = 1'b1;
    clear_logs();
    tick(20);
    check_edges("rst_pw_run_pulse", run_p, 1, 7, 0);
    check("pressed_level_before_rst", int'(run_level), 1);
    Reset = 1'b0;
    #1;
    check("async_rst_level", int'(run_level), 0);
    tick(2);
    Reset = 1'b1;
    clear_logs();
    tick(15);
    check_edges("rst_pr_run_pulse", run_p, 1, 7, 0);
    Run = 1'b1;
    tick(10);
    $display("txn reset_mid: run pulses=%0d", run_p.size());

    // Random key traffic with occasional resets.
    do_reset();
    hr_run = 0;
    hr_cont = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hr_run == 0) begin
        Run = ~Run;
        hr_run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 14);
      end else begin
        hr_run--;
      end
      if (hr_cont == 0) begin
        Continue = ~Continue;
        hr_cont = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 14);
      end else begin
        hr_cont--;
      end
      if ($urandom_range(0, 499) == 0) begin
        Reset = 1'b0;
        tick($urandom_range(1, 3));
        Reset = 1'b1;
      end
      tick(1);
    end
    $display("txn random: run pulses=%0d cont pulses=%0d", run_p.size(), cont_p.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slc3_key_debounce.md
# slc3_key_debounce

Input-conditioning stage that sits directly upstream of the SLC-3 processor top level. It converts the two raw, bouncy, active-low push-button signals (Run, Continue) into synchronised, debounced levels and single-cycle press pulses. The processor's control unit consumes these pulses to start execution and to resume from a pause state.

## Interface
- DEBOUNCE_CYCLES, default 4: consecutive stable synchronised samples required beyond the first change sample (range 1..65535).
- SYNC_STAGES, default 2: synchroniser flop depth per key (range 2..4).

- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Run  input  1  raw Run key; 0 = pressed; asynchronous to Clk.
- Continue  input  1  raw Continue key; 0 = pressed; asynchronous to Clk.
- run_pulse  output  1  high for exactly one cycle per debounced Run press.
- continue_pulse  output  1  high for exactly one cycle per debounced Continue press.
- run_level  output  1  debounced Run state; 1 = pressed.
- continue_level  output  1  debounced Continue state; 1 = pressed.

## Operation
- Two identical, fully independent channels: Run and Continue. There is no interaction or priority between them.
- Synchroniser: SYNC_STAGES flops per key. All flops reset to 1 (released). s = the last stage output.
- Each channel has a counter cnt, width $clog2(DEBOUNCE_CYCLES+1), reset to 0.
- FSM per channel: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is IDLE.
  - IDLE: if s==0, go to PRESS_WAIT with cnt=1. Otherwise stay, cnt=0.
  - PRESS_WAIT:
    - if s==1, go to IDLE with cnt=0 (glitch rejected);
    - else if cnt==DEBOUNCE_CYCLES, go to PRESSED with cnt=0 and assert pulse for the next cycle;
    - else cnt++.
  - PRESSED: if s==1, go to RELEASE_WAIT with cnt=1. Otherwise stay.
  - RELEASE_WAIT:
    - if s==0, go to PRESSED with cnt=0 (bounce rejected, no new pulse);
    - else if cnt==DEBOUNCE_CYCLES, go to IDLE with cnt=0;
    - else cnt++.
- Press qualification: DEBOUNCE_CYCLES+1 consecutive s==0 samples. Release qualification: DEBOUNCE_CYCLES+1 consecutive s==1 samples.
- *_level = 1 in PRESSED or RELEASE_WAIT; 0 in IDLE or PRESS_WAIT. Registered output.
- *_pulse is a registered output, set only on the PRESS_WAIT→PRESSED transition and cleared on the next edge.
- One pulse per qualified press, regardless of hold duration. No pulse on release.
- Counter never exceeds DEBOUNCE_CYCLES; no wrap-around is possible.

## Timing
- Reset asserted (Reset==0): immediately, all synchroniser flops = 1, FSMs = IDLE, cnt = 0, all four outputs = 0. This holds regardless of clock.
- Reset deassertion: the first active edge is the first rising Clk edge with Reset==1.
- Press latency: Run falls before edge k and stays low.
  - s==0 after edge k+SYNC_STAGES-1.
  - PRESS_WAIT entered at edge k+SYNC_STAGES.
  - run_pulse=1 and run_level=1 after edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
  - run_pulse returns to 0 after the next edge.
- Release latency: run_level falls SYNC_STAGES+DEBOUNCE_CYCLES edges after the raw key rises and stays high.
- Minimum accepted low width: DEBOUNCE_CYCLES+1 cycles at s. Shorter lows produce no pulse and no level change.
- Both keys pressed at the same edge: both pulses are asserted in the same cycle.
- Reset mid-PRESS_WAIT or mid-PRESSED: the channel returns to IDLE.
  - A key still held after reset is treated as a new press.
  - It produces one pulse SYNC_STAGES+DEBOUNCE_CYCLES edges after the first active edge.
- Key held through reset: exactly one pulse after reset deassertion, with the same latency.

## Test plan
Defaults apply: DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
- Clean press: Run low before edge 10, held for 20 cycles → run_pulse high only between edges 16 and 17; run_level 1 from edge 16; continue outputs stay 0.
- Glitch rejection: Run low for 4 cycles, then high → no run_pulse; run_level stays 0.
- Bounce: Run toggles 0/1 every cycle for 6 cycles, then held low → exactly one run_pulse, 6 edges after the final stable low begins.
- Long hold and re-press: Run held low for 50 cycles, released for 10, pressed again for 10 → exactly two run_pulse cycles; run_level drops 6 edges after release.
- Simultaneous keys: Run and Continue fall together before edge 5 → run_pulse and continue_pulse both high between edges 11 and 12.
- Reset mid-operation: Run low; Reset pulsed low at cycle 8 (PRESS_WAIT) for 2 cycles; Run held → all outputs 0 during reset; one run_pulse 6 edges after the first edge with Reset==1.
